tno_tnc_scheduler: RTL and testbench

Generates the 1 µs timebase and the cycle (TNC) and frame (TNO) marker strobes consumed by the TNO/TNC interval-measurement logic. Period and frame length are programmable through a small write port, and new values are applied only at frame boundaries. A start/stop state machine sequences the markers. The block sits between the control-register decoder and the measurement block, and its outputs connect directly to that block's `clk1us`, `reset_TNC` and `reset_TNO` inputs.

---
 rtl/tno_tnc_pkg.sv | 38 +++
 rtl/tno_tnc_scheduler_us_prescaler.sv | 42 ++++
 rtl/tno_tnc_scheduler.sv | 179 +++++++++++++++++
 tb/tb_tno_tnc_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tno_tnc_pkg.sv
// tno_tnc_pkg: shared types and constants for the TNO/TNC
// marker scheduler.
package tno_tnc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic CFG_TNC_US  = 1'b0;
    localparam logic CFG_PER_TNO = 1'b1;

    localparam int unsigned MIN_TNC_US = 2;

    localparam int unsigned CLK_PER_US_RST = 100;
    localparam int unsigned PULSE_CLKS_RST = 8;
    localparam int unsigned TNC_US_RST     = 1000;
    localparam int unsigned PER_TNO_RST    = 4;

    function automatic logic cfg_valid(
        input logic        addr,
        input logic [31:0] data
    );
        logic ok;
        ok = 1'b0;
        unique case (1'b1)
            (addr == CFG_TNC_US):
                ok = (data >= 32'(MIN_TNC_US));
            (addr == CFG_PER_TNO):
                ok = (data != 32'd0) && (data[31:16] == 16'd0);
            default:
                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tno_tnc_scheduler_us_prescaler.sv
// us_prescaler: free-running clk-to-microsecond divider,
// producing the tick and the 50 % clk1us square wave.
module us_prescaler #(
    parameter int unsigned CLK_PER_US = 100
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic clk1us
);

    localparam int PW = $clog2(CLK_PER_US);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_PER_US - 1);
    localparam logic [PW-1:0] P_HALF = PW'(CLK_PER_US / 2 - 1);

    logic [PW-1:0] p;

    assign tick = (p == P_LAST);

    // Prescaler counter, wraps at the tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p <= '0;
        end else if (tick) begin
            p <= '0;
        end else begin
            p <= p + 1'b1;
        end
    end

    // clk1us is high for the first half of each microsecond.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk1us <= 1'b0;
        end else if (tick) begin
            clk1us <= 1'b1;
        end else if (p == P_HALF) begin
            clk1us <= 1'b0;
        end
    end

endmodule

// File: rtl/tno_tnc_scheduler.sv
// tno_tnc_scheduler: 1 us timebase plus TNC/TNO marker
// strobes with frame-aligned reconfiguration.
module tno_tnc_scheduler
    import tno_tnc_pkg::*;
#(
    parameter int unsigned CLK_PER_US      = CLK_PER_US_RST,
    parameter int unsigned PULSE_CLKS      = PULSE_CLKS_RST,
    parameter int unsigned DEF_TNC_US      = TNC_US_RST,
    parameter int unsigned DEF_TNC_PER_TNO = PER_TNO_RST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        cfg_we,
    input  logic        cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic        cfg_err,
    output logic        busy,
    output logic        clk1us,
    output logic        reset_TNC,
    output logic        reset_TNO,
    output logic [15:0] tnc_idx,
    output logic [31:0] frame_cnt
);

    localparam int SW = $clog2(PULSE_CLKS + 1);
    localparam logic [SW-1:0] PULSE_LD = SW'(PULSE_CLKS);
    localparam logic [31:0] TNC_DEF = 32'(DEF_TNC_US);
    localparam logic [15:0] PER_DEF = 16'(DEF_TNC_PER_TNO);

    state_e        state;
    logic          stop_pend;
    logic          tick;
    logic [31:0]   sh_tnc_us;
    logic [15:0]   sh_per_tno;
    logic [31:0]   act_tnc_us;
    logic [15:0]   act_per_tno;
    logic [31:0]   us_cnt;
    logic [SW-1:0] tnc_str;
    logic [SW-1:0] tno_str;

    logic period_end;
    logic last_cyc;
    logic arm_go;
    logic run_end;
    logic frame_end;
    logic fire_tnc;
    logic fire_tno;

    us_prescaler #(
        .CLK_PER_US (CLK_PER_US)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .clk1us (clk1us)
    );

    assign period_end = (us_cnt == act_tnc_us - 32'd1);
    assign last_cyc   = (tnc_idx == act_per_tno - 16'd1);
    assign arm_go     = (state == ST_ARM) && tick && !stop;
    assign run_end    = (state == ST_RUN) && tick && period_end;
    assign frame_end  = run_end && last_cyc;
    assign fire_tnc   = arm_go ||
                        (run_end && !(frame_end && stop_pend));
    assign fire_tno   = arm_go || (frame_end && !stop_pend);

    assign busy      = (state != ST_IDLE);
    assign reset_TNC = (tnc_str != '0);
    assign reset_TNO = (tno_str != '0);

    // Start/stop sequencing; a stop in RUN waits for the frame end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            stop_pend <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (frame_end && stop_pend) begin
                        state     <= ST_IDLE;
                        stop_pend <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    stop_pend <= 1'b0;
                end
            endcase
        end
    end

    // Config shadows; bad values are dropped and flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_tnc_us  <= TNC_DEF;
            sh_per_tno <= PER_DEF;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (cfg_we) begin
                if (!cfg_valid(cfg_addr, cfg_wdata)) begin
                    cfg_err <= 1'b1;
                end else if (cfg_addr == CFG_TNC_US) begin
                    sh_tnc_us <= cfg_wdata;
                end else begin
                    sh_per_tno <= cfg_wdata[15:0];
                end
            end
        end
    end

    // Microsecond, cycle and frame counters plus active reload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            us_cnt      <= '0;
            tnc_idx     <= '0;
            frame_cnt   <= '0;
            act_tnc_us  <= TNC_DEF;
            act_per_tno <= PER_DEF;
        end else if (arm_go) begin
            us_cnt      <= '0;
            tnc_idx     <= '0;
            frame_cnt   <= '0;
            act_tnc_us  <= sh_tnc_us;
            act_per_tno <= sh_per_tno;
        end else if ((state == ST_RUN) && tick) begin
            if (period_end) begin
                us_cnt <= '0;
                if (last_cyc) begin
                    tnc_idx     <= '0;
                    frame_cnt   <= frame_cnt + 32'd1;
                    act_tnc_us  <= sh_tnc_us;
                    act_per_tno <= sh_per_tno;
                end else begin
                    tnc_idx <= tnc_idx + 16'd1;
                end
            end else begin
                us_cnt <= us_cnt + 32'd1;
            end
        end
    end

    // Strobe stretchers, reloaded on every fire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tnc_str <= '0;
            tno_str <= '0;
        end else begin
            if (fire_tnc) begin
                tnc_str <= PULSE_LD;
            end else if (tnc_str != '0) begin
                tnc_str <= tnc_str - 1'b1;
            end
            if (fire_tno) begin
                tno_str <= PULSE_LD;
            end else if (tno_str != '0) begin
                tno_str <= tno_str - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tno_tnc_scheduler.sv
// tb_tno_tnc_scheduler: scoreboard bench for the marker
// scheduler with CLK_PER_US=10 and PULSE_CLKS=4.
module tb_tno_tnc_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cfg_we = 1'b0;
    logic        cfg_addr = 1'b0;
    logic [31:0] cfg_wdata = '0;
    logic        cfg_err;
    logic        busy;
    logic        clk1us;
    logic        reset_TNC;
    logic        reset_TNO;
    logic [15:0] tnc_idx;
    logic [31:0] frame_cnt;

    tno_tnc_scheduler #(
        .CLK_PER_US      (10),
        .PULSE_CLKS      (4),
        .DEF_TNC_US      (3),
        .DEF_TNC_PER_TNO (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .clk1us    (clk1us),
        .reset_TNC (reset_TNC),
        .reset_TNO (reset_TNO),
        .tnc_idx   (tnc_idx),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int   c;
        logic tno;
        int   idx;
        int   frame;
    } sev_t;

    typedef struct {
        int   c;
        logic up;
    } bev_t;

    sev_t q_str[$];
    int   q_err[$];
    bev_t q_busy[$];

    task automatic chk(string name, longint got, longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                     name, cyc, got, exp);
        end
    endtask

    function automatic sev_t sev(int c, logic t, int i, int f);
        sev_t e;
        e.c = c; e.tno = t; e.idx = i; e.frame = f;
        return e;
    endfunction

    function automatic bev_t bev(int c, logic up);
        bev_t e;
        e.c = c; e.up = up;
        return e;
    endfunction

    task automatic wait_cyc(int n);
        while (cyc < n) @(negedge clk);
        if (cyc != n) begin
            n_tests++;
            n_fail++;
            $display("FAIL sched: at cyc %0d, wanted %0d", cyc, n);
        end
    endtask

    task automatic cfg(int n, logic a, logic [31:0] d);
        wait_cyc(n);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        wait_cyc(n + 1);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start(int n);
        wait_cyc(n);
        start = 1'b1;
        wait_cyc(n + 1);
        start = 1'b0;
    endtask

    task automatic pulse_stop(int n);
        wait_cyc(n);
        stop = 1'b1;
        wait_cyc(n + 1);
        stop = 1'b0;
    endtask

    // Monitor: compare every DUT event against the queues.
    logic p_tnc = 1'b0, p_tno = 1'b0, p_busy = 1'b0;
    int   w_tnc = 0, w_tno = 0;

    always @(negedge clk) begin
        logic rt, ro;
        sev_t e;
        bev_t b;
        if (!rst) begin
            p_tnc = 1'b0; p_tno = 1'b0; p_busy = 1'b0;
            w_tnc = 0; w_tno = 0;
        end else begin
            chk("clk1us", clk1us, (cyc >= 10 && cyc % 10 < 5));
            rt = reset_TNC && !p_tnc;
            ro = reset_TNO && !p_tno;
            if (rt || ro) begin
                n_tests++;
                if (q_str.size() == 0) begin
                    n_fail++;
                    $display("FAIL strobe @cyc %0d: unexpected tnc=%0b tno=%0b",
                             cyc, rt, ro);
                end else begin
                    e = q_str.pop_front();
                    if (cyc != e.c || ro != e.tno || !rt ||
                        tnc_idx != e.idx || frame_cnt != e.frame) begin
                        n_fail++;
                        $display({"FAIL strobe: got cyc %0d tnc %0b tno %0b",
                                  " idx %0d frame %0d, expected cyc %0d",
                                  " tno %0b idx %0d frame %0d"},
                                 cyc, rt, ro, tnc_idx, frame_cnt,
                                 e.c, e.tno, e.idx, e.frame);
                    end
                end
            end
            if (reset_TNC) w_tnc++;
            else if (p_tnc) begin
                chk("tnc_width", w_tnc, 4);
                w_tnc = 0;
            end
            if (reset_TNO) w_tno++;
            else if (p_tno) begin
                chk("tno_width", w_tno, 4);
                w_tno = 0;
            end
            if (cfg_err) begin
                if (q_err.size() == 0) chk("cfg_err_unexp", cyc, -1);
                else chk("cfg_err_cyc", cyc, q_err.pop_front());
            end
            if (busy != p_busy) begin
                if (q_busy.size() == 0) begin
                    chk("busy_unexp", busy, p_busy);
                end else begin
                    b = q_busy.pop_front();
                    chk("busy_cyc", cyc, b.c);
                    chk("busy_dir", busy, b.up);
                end
            end
            p_tnc = reset_TNC; p_tno = reset_TNO; p_busy = busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation ran too long");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_clk1us", clk1us, 0);
        chk("rst_tnc", reset_TNC, 0);
        chk("rst_tno", reset_TNO, 0);
        chk("rst_idx", tnc_idx, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_err", cfg_err, 0);
        rst = 1'b1;

        // period 5 us, 3 cycles per frame
        cfg(40, 1'b0, 32'd5);
        cfg(41, 1'b1, 32'd3);
        q_busy.push_back(bev(46, 1'b1));
        q_str.push_back(sev(50, 1'b1, 0, 0));
        q_str.push_back(sev(100, 1'b0, 1, 0));
        q_str.push_back(sev(150, 1'b0, 2, 0));
        q_str.push_back(sev(200, 1'b1, 0, 1));
        q_str.push_back(sev(250, 1'b0, 1, 1));
        q_str.push_back(sev(300, 1'b0, 2, 1));
        q_str.push_back(sev(350, 1'b1, 0, 2));
        pulse_start(45);

        // mid-frame period change takes effect at next TNO
        cfg(260, 1'b0, 32'd8);
        q_str.push_back(sev(430, 1'b0, 1, 2));
        q_str.push_back(sev(510, 1'b0, 2, 2));
        q_str.push_back(sev(590, 1'b1, 0, 3));

        // rejected writes
        q_err.push_back(361);
        cfg(360, 1'b0, 32'd1);
        q_err.push_back(363);
        cfg(362, 1'b1, 32'd0);
        q_err.push_back(365);
        cfg(364, 1'b1, 32'h0001_0000);
        q_str.push_back(sev(670, 1'b0, 1, 3));
        q_str.push_back(sev(750, 1'b0, 2, 3));
        q_str.push_back(sev(830, 1'b1, 0, 4));

        // stop at idx 0: frame completes silently
        q_str.push_back(sev(910, 1'b0, 1, 4));
        q_str.push_back(sev(990, 1'b0, 2, 4));
        q_busy.push_back(bev(1070, 1'b0));
        pulse_stop(840);
        wait_cyc(1069);
        chk("busy_pre_stop", busy, 1);
        wait_cyc(1070);
        chk("busy_at_stop", busy, 0);
        chk("frame_at_stop", frame_cnt, 5);
        chk("idx_at_stop", tnc_idx, 0);

        // start and stop together: stays idle
        wait_cyc(1100);
        start = 1'b1; stop = 1'b1;
        wait_cyc(1101);
        start = 1'b0; stop = 1'b0;
        wait_cyc(1120);
        chk("idle_after_collide", busy, 0);

        // run again, reset during a TNC strobe
        q_busy.push_back(bev(1131, 1'b1));
        q_str.push_back(sev(1140, 1'b1, 0, 0));
        q_str.push_back(sev(1220, 1'b0, 1, 0));
        q_str.push_back(sev(1300, 1'b0, 2, 0));
        q_str.push_back(sev(1380, 1'b1, 0, 1));
        q_str.push_back(sev(1460, 1'b0, 1, 1));
        pulse_start(1130);
        wait_cyc(1461);
        chk("pre_rst_tnc", reset_TNC, 1);
        chk("pre_rst_frame", frame_cnt, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_tnc", reset_TNC, 0);
        chk("arst_tno", reset_TNO, 0);
        chk("arst_busy", busy, 0);
        chk("arst_frame", frame_cnt, 0);
        chk("arst_idx", tnc_idx, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // defaults after reset: 3 us, 2 cycles per frame
        q_busy.push_back(bev(6, 1'b1));
        q_str.push_back(sev(10, 1'b1, 0, 0));
        q_str.push_back(sev(40, 1'b0, 1, 0));
        q_str.push_back(sev(70, 1'b1, 0, 1));
        q_str.push_back(sev(100, 1'b0, 1, 1));
        q_busy.push_back(bev(130, 1'b0));
        pulse_start(5);
        pulse_stop(75);
        wait_cyc(130);
        chk("frame_dflt_stop", frame_cnt, 2);
        wait_cyc(150);

        chk("q_str_left", q_str.size(), 0);
        chk("q_err_left", q_err.size(), 0);
        chk("q_busy_left", q_busy.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
